// File: rtl/instr_trace_buffer.sv
// Retirement trace FIFO with halt detection (ECALL or a stuck PC) and a run-cycle counter.
// Optional TRACE_OVERWRITE_EN: a full buffer overwrites its oldest entry instead of dropping the new one.
module instr_trace_buffer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HALT_THRESH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cap_en,
  input  logic                   clr,
  input  logic [31:0]            pc_i,
  input  logic [31:0]            instr_i,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [31:0]            rd_pc,
  output logic [31:0]            rd_instr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   halted,
  output logic [31:0]            cycle_count
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam logic [31:0] ECALL = 32'h0000_0073;
`ifdef TRACE_OVERWRITE_EN
  localparam bit OVERWRITE = 1'b1;
`else
  localparam bit OVERWRITE = 1'b0;
`endif

  typedef enum logic [1:0] {S_RUN, S_STALL, S_HALTED} state_t;

  state_t        r_state;
  logic [31:0]   r_last_pc;
  logic [31:0]   r_rpt;
  logic          r_halted;
  logic [31:0]   r_cycle_count;
  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [31:0]   r_rd_pc;
  logic [31:0]   r_rd_instr;

  logic          w_capture;
  logic          w_pop;
  logic          w_full;
  logic          w_lost;
  logic          w_push;
  logic          w_head_adv;
  logic [AW-1:0] w_head_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [63:0]   w_head_data;

  always_comb begin
    w_capture   = cap_en && (r_state != S_HALTED) && !clr && !reset;
    w_pop       = (r_count != '0) && rd_ready;
    w_full      = (r_count == CW'(DEPTH));
    w_lost      = w_capture && w_full && !w_pop;
    w_push      = w_capture && (!w_lost || OVERWRITE);
    w_head_adv  = w_pop || (w_lost && OVERWRITE);
    w_head_nxt  = r_head + AW'(w_head_adv);
    w_count_nxt = r_count;
    if (w_push && !w_head_adv)
      w_count_nxt = r_count + CW'(1);
    else if (w_pop && !w_push)
      w_count_nxt = r_count - CW'(1);
    // New head may be the slot being written this edge; forward it so rd_* is registered head data
    if (w_push && (w_head_nxt == r_tail))
      w_head_data = {pc_i, instr_i};
    else
      w_head_data = r_mem[w_head_nxt];
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_tail] <= {pc_i, instr_i};
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_rd_pc    <= '0;
      r_rd_instr <= '0;
    end else begin
      if (w_push)
        r_tail <= r_tail + AW'(1);
      r_head  <= w_head_nxt;
      r_count <= w_count_nxt;
      if (w_lost)
        r_overflow <= 1'b1;
      if (w_count_nxt != '0) begin
        r_rd_pc    <= w_head_data[63:32];
        r_rd_instr <= w_head_data[31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_state       <= S_RUN;
      r_last_pc     <= '0;
      r_rpt         <= '0;
      r_halted      <= 1'b0;
      r_cycle_count <= '0;
    end else if (cap_en && (r_state != S_HALTED)) begin
      r_last_pc     <= pc_i;
      r_cycle_count <= r_cycle_count + 32'd1;
      case (r_state)
        S_RUN: begin
          if (instr_i == ECALL) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end else if (pc_i == r_last_pc) begin
            r_rpt   <= 32'd1;
            r_state <= S_STALL;
          end
        end
        S_STALL: begin
          if (pc_i != r_last_pc) begin
            r_rpt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_rpt <= r_rpt + 32'd1;
            if ((r_rpt + 32'd1) >= HALT_THRESH) begin
              r_state  <= S_HALTED;
              r_halted <= 1'b1;
            end
          end
        end
        default: r_state <= S_HALTED;
      endcase
    end
  end

  assign rd_valid    = (r_count != '0);
  assign rd_pc       = r_rd_pc;
  assign rd_instr    = r_rd_instr;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign halted      = r_halted;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Scoreboard bench for instr_trace_buffer: a queue-based reference model predicts state and popped entries;
// a negedge monitor compares DUT status every cycle and each popped entry.
module tb_instr_trace_buffer;
  localparam int unsigned DEPTH       = 16;
  localparam int unsigned HALT_THRESH = 4;
  localparam int unsigned CW          = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, cap_en, clr, rd_ready;
  logic [31:0]   pc_i, instr_i;
  logic          rd_valid, overflow, halted;
  logic [31:0]   rd_pc, rd_instr, cycle_count;
  logic [CW-1:0] count;

  instr_trace_buffer #(.DEPTH(DEPTH), .HALT_THRESH(HALT_THRESH)) dut (
    .clk(clk), .reset(reset), .cap_en(cap_en), .clr(clr), .pc_i(pc_i), .instr_i(instr_i),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .count(count), .overflow(overflow), .halted(halted), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          hlt;
    logic [31:0]   cc;
    logic          chk_head;
    logic [63:0]   head;
  } status_t;

  status_t     stq[$];
  logic [63:0] sb[$];
  logic [63:0] mq[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          mon_en   = 0;

  logic        m_ovf, m_halt, m_zero;
  logic [31:0] m_cc, m_last, last_drv;
  int          m_streak;
  status_t     mon_s;
  logic [63:0] mon_e;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (stq.size() == 0) begin
        n_checks++;
        $display("FAIL status_queue: got empty expected entry at %0t", $time);
      end else begin
        mon_s = stq.pop_front();
        chk("rd_valid", 64'(rd_valid), 64'(mon_s.valid));
        chk("count", 64'(count), 64'(mon_s.cnt));
        chk("overflow", 64'(overflow), 64'(mon_s.ovf));
        chk("halted", 64'(halted), 64'(mon_s.hlt));
        chk("cycle_count", 64'(cycle_count), 64'(mon_s.cc));
        if (mon_s.chk_head) chk("head", {rd_pc, rd_instr}, mon_s.head);
      end
      if (rd_valid && rd_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL pop: got %0h expected no entry at %0t", {rd_pc, rd_instr}, $time);
        end else begin
          mon_e = sb.pop_front();
          chk("pop", {rd_pc, rd_instr}, mon_e);
        end
      end
    end
  end

  // Reference: the buffer is a plain queue; halt is an ECALL outside a repeat run, or a run of
  // HALT_THRESH consecutive captured cycles whose PC equals the previous captured PC.
  task automatic step(input bit rst, input bit c, input bit cap, input bit rdy,
                      input logic [31:0] pc, input logic [31:0] ins);
    status_t     s;
    bit          pop;
    logic [63:0] e;
    reset = rst; clr = c; cap_en = cap; rd_ready = rdy; pc_i = pc; instr_i = ins;
    last_drv   = pc;
    s.valid    = (mq.size() > 0);
    s.cnt      = CW'(mq.size());
    s.ovf      = m_ovf;
    s.hlt      = m_halt;
    s.cc       = m_cc;
    s.chk_head = s.valid || m_zero;
    s.head     = s.valid ? mq[0] : 64'h0;
    stq.push_back(s);
    pop = s.valid && rdy;
    if (pop) sb.push_back(mq[0]);
    e = {pc, ins};
    if (rst || c) begin
      mq.delete();
      m_ovf = 0; m_halt = 0; m_cc = 0; m_last = 0; m_streak = 0; m_zero = 1;
    end else begin
      if (pop) void'(mq.pop_front());
      if (cap && !m_halt) begin
        if (mq.size() == DEPTH) begin
          m_ovf = 1;
`ifdef TRACE_OVERWRITE_EN
          void'(mq.pop_front());
          mq.push_back(e);
          m_zero = 0;
`endif
        end else begin
          mq.push_back(e);
          m_zero = 0;
        end
        m_cc = m_cc + 32'd1;
        if (m_streak == 0 && ins == 32'h0000_0073) m_halt = 1;
        else if (pc == m_last) begin
          m_streak++;
          if (m_streak >= int'(HALT_THRESH)) m_halt = 1;
        end else m_streak = 0;
        m_last = pc;
      end
    end
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rnd_ins();
    return $urandom | 32'h0000_0100;
  endfunction

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0, base + 32'(4 * i), rnd_ins());
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1; clr = 0; cap_en = 0; rd_ready = 0; pc_i = 0; instr_i = 0; last_drv = 0;
    m_ovf = 0; m_halt = 0; m_cc = 0; m_last = 0; m_streak = 0; m_zero = 1;
    @(posedge clk);
    #2;
    mon_en = 1;
    step(1, 0, 0, 0, 32'h0, 32'h0);

    fill(16, 32'h0);
    drain(17);

    step(1, 0, 0, 0, 32'h0, 32'h0);
    fill(17, 32'h0);
    drain(17);

    step(0, 1, 0, 0, 32'h0, 32'h0);
    fill(16, 32'h200);
    step(0, 0, 1, 1, 32'h300, rnd_ins());
    drain(17);

    step(0, 1, 0, 0, 32'h0, 32'h0);
    step(0, 0, 1, 0, 32'h10, rnd_ins());
    step(0, 0, 1, 0, 32'h14, rnd_ins());
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 32'h18, rnd_ins());
    step(0, 0, 1, 0, 32'h40, rnd_ins());
    step(0, 0, 1, 0, 32'h44, rnd_ins());
    drain(10);

    step(0, 1, 0, 0, 32'h0, 32'h0);
    step(0, 0, 1, 0, 32'h1c, rnd_ins());
    step(0, 0, 1, 0, 32'h20, 32'h0000_0073);
    step(0, 0, 1, 0, 32'h24, rnd_ins());
    step(0, 0, 1, 1, 32'h28, rnd_ins());
    step(0, 1, 1, 0, 32'h2c, rnd_ins());
    step(0, 0, 0, 0, 32'h0, 32'h0);

    step(0, 1, 0, 0, 32'h0, 32'h0);
    fill(7, 32'h80);
    step(1, 0, 1, 1, 32'h99, rnd_ins());
    step(0, 0, 0, 1, 32'h0, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc, ins;
      pc  = ($urandom_range(0, 9) < 3) ? last_drv : (32'($urandom_range(0, 7)) << 2);
      ins = ($urandom_range(0, 29) == 0) ? 32'h0000_0073 : rnd_ins();
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 99) < 85), 1'($urandom_range(0, 1)), pc, ins);
    end
    drain(18);

    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
